// File: rtl/mul_sequencer.sv
// mul_sequencer
// Multi-cycle shift-add unsigned multiplier controller for the MiniAlu datapath.
// It computes WIDTH x WIDTH -> 2*WIDTH products in a fixed WIDTH steps.
// While it runs, it stalls fetch/decode. When the product is ready, it issues a
// one-cycle write strobe for the data RAM write port.
//
// Ports:
//   Clock          system clock, rising edge
//   Reset          asynchronous active-low reset
//   iStart         decoded MUL opcode (level, held by the stalled decode register)
//   iFlush         synchronous abort (branch taken / pipeline flush)
//   iA, iB         multiplicand / multiplier, sampled on the start edge only
//   iDestination   RAM destination address, sampled on the start edge only
//   oStall         hold IP counter and decode registers
//   oBusy          sequencer is not idle
//   oWriteEnable   one-cycle RAM write strobe
//   oWriteAddress  latched destination address
//   oResult        low half of the last completed product
//   oResultHigh    high half of the last completed product
//   oOverflow      high half of the last completed product is non-zero
module mul_sequencer #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iStart,
   input  logic                  iFlush,
   input  logic [WIDTH-1:0]      iA,
   input  logic [WIDTH-1:0]      iB,
   input  logic [ADDR_WIDTH-1:0] iDestination,
   output logic                  oStall,
   output logic                  oBusy,
   output logic                  oWriteEnable,
   output logic [ADDR_WIDTH-1:0] oWriteAddress,
   output logic [WIDTH-1:0]      oResult,
   output logic [WIDTH-1:0]      oResultHigh,
   output logic                  oOverflow
);

   localparam int unsigned CountWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CountWidth-1:0] LastCount = CountWidth'(WIDTH - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;

   logic [1:0]            stateQ, stateD;
   logic [2*WIDTH-1:0]    mcandQ;
   logic [WIDTH-1:0]      mplrQ;
   logic [2*WIDTH-1:0]    accQ;
   logic [2*WIDTH-1:0]    accStep;
   logic [CountWidth-1:0] countQ;
   logic [ADDR_WIDTH-1:0] addrQ;
   logic [2*WIDTH-1:0]    productQ;
   logic                  startAccept;
   logic                  lastStep;

   assign startAccept = (stateQ == StIdle) && iStart && !iFlush;
   assign lastStep    = (stateQ == StRun) && !iFlush && (countQ == LastCount);

   // Partial sum including the current step.
   // The last step's value goes straight into the product register.
   assign accStep = mplrQ[0] ? (accQ + mcandQ) : accQ;

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:  if (startAccept) stateD = StRun;
         StRun: begin
            if (iFlush) begin
               stateD = StIdle;
            end else if (countQ == LastCount) begin
               stateD = StWrite;
            end
         end
         // iStart is still high from the same stalled MUL, so it is not a new start
         StWrite: stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         stateQ   <= StIdle;
         mcandQ   <= '0;
         mplrQ    <= '0;
         accQ     <= '0;
         countQ   <= '0;
         addrQ    <= '0;
         productQ <= '0;
      end else begin
         stateQ <= stateD;
         if (startAccept) begin
            mcandQ <= {{WIDTH{1'b0}}, iA};
            mplrQ  <= iB;
            accQ   <= '0;
            countQ <= '0;
            addrQ  <= iDestination;
         end else if ((stateQ == StRun) && !iFlush) begin
            accQ   <= accStep;
            mcandQ <= mcandQ << 1;
            mplrQ  <= mplrQ >> 1;
            countQ <= countQ + CountWidth'(1);
            if (lastStep) begin
               productQ <= accStep;
            end
         end
      end
   end

   // Gate the combinational start term with Reset so every output reads 0 during reset.
   assign oStall        = Reset && (startAccept || (stateQ == StRun));
   assign oBusy         = (stateQ != StIdle);
   assign oWriteEnable  = (stateQ == StWrite);
   assign oWriteAddress = addrQ;
   assign oResult       = productQ[WIDTH-1:0];
   assign oResultHigh   = productQ[2*WIDTH-1:WIDTH];
   assign oOverflow     = |productQ[2*WIDTH-1:WIDTH];

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle shift-add multiply controller for the MiniAlu datapath. It replaces the combinational 4x4 array multiplier with a full WIDTH x WIDTH unsigned multiply. While the multiply runs, it stalls instruction fetch and the decode registers. When the product is ready, it issues a one-cycle write into the data RAM write port. It sits between the opcode decode (MUL opcode) and the RAM_DUAL_READ_PORT write port, and its write is muxed onto that port.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH bits.
- ADDR_WIDTH, 8, data RAM address width.

- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iStart  in  1  decoded opcode is MUL; level, held by the stalled decode register.
- iFlush  in  1  synchronous abort (branch taken / pipeline flush).
- iA  in  WIDTH  multiplicand (wSourceData1).
- iB  in  WIDTH  multiplier (wSourceData0).
- iDestination  in  ADDR_WIDTH  RAM destination address.
- oStall  out  1  hold IP counter and decode registers.
- oBusy  out  1  state != IDLE.
- oWriteEnable  out  1  one-cycle RAM write strobe.
- oWriteAddress  out  ADDR_WIDTH  latched destination.
- oResult  out  WIDTH  low half of the last completed product.
- oResultHigh  out  WIDTH  high half of the last completed product.
- oOverflow  out  1  oResultHigh != 0 for the last completed product.

## Operation
- States: IDLE, RUN, WRITE. Encoding is free. Reset state is IDLE.
- IDLE with iStart=1 and iFlush=0:
  - Load mcand = {WIDTH'b0, iA}, mplr = iB, acc = 0, count = 0.
  - Latch iDestination.
  - Go to RUN.
- RUN, each cycle:
  - If mplr[0], then acc <= acc + mcand (2*WIDTH bits; no carry out is possible).
  - mcand <<= 1; mplr >>= 1; count++.
  - When count == WIDTH-1 on this step, go to WRITE.
  - Latency is fixed at WIDTH steps. There is no early exit for zero operands.
- Entering WRITE:
  - Product register <= acc.
  - oResult/oResultHigh/oOverflow update from the product register.
- WRITE: oWriteEnable=1 for exactly one cycle, then go to IDLE unconditionally.
  - iStart is ignored in WRITE. It is still high from the same stalled instruction, so it must not retrigger.
- iFlush=1 in RUN: go to IDLE next edge. No write; product register unchanged.
- iFlush=1 in IDLE suppresses start. iFlush in WRITE is ignored; the write completes.
- iStart while in RUN: ignored.
- oStall = (IDLE & iStart & ~iFlush) | RUN. This is combinational so the IP does not advance on the start edge.
- oStall is 0 in WRITE, so fetch resumes on the same edge the RAM write occurs.
- oWriteEnable and oBusy are decoded from the state register only (no combinational input path).
- Reset low, at any time including mid-RUN:
  - State goes to IDLE.
  - acc, mcand, mplr, count, latched address, and product register are cleared.
  - All outputs read 0 immediately, without waiting for a clock.

## Timing
- Cycle 0: iStart sampled in IDLE; oStall=1.
- Cycles 1..WIDTH: RUN; oStall=1, oBusy=1.
- Cycle WIDTH+1: WRITE; oWriteEnable=1, oStall=0; oResult valid.
- Cycle WIDTH+2: IDLE. Next instruction's iStart can be accepted here.
- Total stall: WIDTH+1 cycles. Issue-to-write latency: WIDTH+1 cycles.
- Product outputs are stable from WRITE until the next WRITE.
- iA, iB, iDestination are sampled only on the start edge. They may change afterward.

## Test plan
- Basic multiply (WIDTH=16): iA=3, iB=5, iStart pulse.
  - oStall high cycles 0..16.
  - oWriteEnable only at cycle 17.
  - oResult=15, oResultHigh=0, oOverflow=0.
- Max operands: iA=0xFFFF, iB=0xFFFF.
  - oResult=0x0001, oResultHigh=0xFFFE, oOverflow=1.
  - Write address equals iDestination=0x2A sampled at start.
- Held iStart: iStart held high through WRITE.
  - Exactly one oWriteEnable.
  - IDLE at cycle 18.
  - A new start at cycle 18 (iA=7, iB=6) writes 42 at cycle 35.
- Flush: iFlush at cycle 5 of a 9*9 run.
  - Back to IDLE at cycle 6, oStall=0, no write.
  - oResult keeps the prior value (42).
- Async reset: Reset low mid-RUN, between clock edges.
  - oStall, oBusy, oWriteEnable, oResult, oResultHigh all 0 before the next edge.
  - A restart after release gives the correct product.
- Zero operand: iA=0, iB=0x1234.
  - Full WIDTH+1 latency, oResult=0, oOverflow=0.
